multi_strand_led_driver: RTL
============================

Name: multi_strand_led_driver

Overview:
Drives NUM_STRANDS WS2812-style serial LED strands in lockstep from one shared bit-timing engine. Each frame fetches per-LED colours for all strands through a single indexed request/valid handshake. The engine prefetches the next LED during shifting, applies a global brightness shift, and supports one-shot or continuous refresh. It sits between the pixel source (framebuffer or pattern generator) and the PMOD strand pins, replacing the single-strand driver.

Parameters:
NUM_STRANDS, 4, number of parallel strands
NUM_LEDS, 60, LEDs per strand (>=1)
COLOR_WIDTH, 8, bits per colour channel
T_BIT, 125, clock cycles per data bit (1.25 us @100 MHz)
T0H, 40, high cycles for a 0 bit
T1H, 80, high cycles for a 1 bit
RESET_CYCLES, 30000, latch/low time after a frame

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
force_reset  in  1  abort the current frame and drive the latch period
frame_start  in  1  one-cycle pulse that starts one frame when idle
mode_continuous  in  1  1 = auto-restart frames; sampled in IDLE and at end of RESET
brightness_shift_in  in  3  right-shift applied to every channel at capture
green_in  in  NUM_STRANDS*COLOR_WIDTH  strand s at [s*CW +: CW]
red_in  in  NUM_STRANDS*COLOR_WIDTH  same packing
blue_in  in  NUM_STRANDS*COLOR_WIDTH  same packing
color_valid  in  1  colour buses valid for next_led_request
next_led_request  out  $clog2(NUM_LEDS) (min 1)  LED index requested
request_valid  out  1  request outstanding
strand_out  out  NUM_STRANDS  serial data lines
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse after a complete frame's latch period
underrun  out  1  one-cycle pulse when colour data was late

Behaviour:
- Reset: all outputs 0. State = IDLE. Prefetch buffer empty.
- States: IDLE, FETCH0, SHIFT, LATCH.
- IDLE -> FETCH0 on frame_start, or when mode_continuous=1.
- FETCH0: request_valid=1, next_led_request=0. Waits indefinitely; strand_out stays 0.
- Handshake: capture occurs on any cycle where request_valid && color_valid. request_valid drops the following cycle. color_valid without an outstanding request is ignored.
- Capture formatting: word = {G,R,B}, each channel >> brightness_shift_in. This gives 3*COLOR_WIDTH bits, sent MSB first, with all strands captured together.
- FETCH0 capture -> SHIFT next cycle, LED 0.
- SHIFT timing: a shared bit counter runs 0..T_BIT-1. strand_out[s] = (cnt < (bit_s ? T1H : T0H)).
- Prefetch: on the first cycle of LED k (k < NUM_LEDS-1), request index k+1 into the prefetch buffer.
- End of LED k's last bit:
  - k = NUM_LEDS-1 -> LATCH (complete).
  - Prefetch full -> load it and start LED k+1 with no gap cycle.
  - Prefetch empty -> underrun pulse, request withdrawn, LATCH (aborted).
- A capture landing on the exact cycle the last bit ends counts as in time.
- LATCH: strand_out=0 for RESET_CYCLES cycles.
  - Complete frame: frame_done pulses on the final LATCH cycle.
  - Then FETCH0 if mode_continuous=1, else IDLE.
- force_reset (any state, including LATCH):
  - Next cycle: strand_out=0, request_valid=0, prefetch cleared.
  - LATCH restarts a full RESET_CYCLES, then IDLE. No frame_done.
  - Takes priority over frame_start and capture on the same cycle.
- frame_start is ignored while busy.
- rst_in mid-frame: returns to the reset state next cycle. No latch period is generated.
- NUM_LEDS=1: no prefetch requests occur.

Test Plan:
Common setup: NUM_STRANDS=2, NUM_LEDS=3, CW=8, T_BIT=10, T0H=3, T1H=7, RESET_CYCLES=50. Source answers color_valid 2 cycles after each request.
- One-shot frame: strand0 G=0xFF R=0 B=0x01, strand1 all 0x00, shift 0, frame_start pulse. Required: strand0 sends 8 pulses of 7 high cycles, then 15 of 3 high, then 1 of 7. Strand1 sends 24 pulses of 3 high. 3 LEDs back-to-back with no gap. frame_done after 720+50 cycles. Request indices 0,1,2.
- Brightness: G=0xF0, shift 4. Required: G sent as 0x0F (4 zero bits, then 4 one bits).
- Underrun: source withholds valid for LED 1. Required: after LED 0's 240 cycles, underrun pulses once, strand_out low for 50 cycles, no frame_done, return to IDLE.
- Continuous mode: mode_continuous=1. Required: FETCH0 (request index 0) re-entered the cycle after each LATCH ends. frame_done pulses once per frame over 3 frames.
- force_reset mid-SHIFT on LED 1, simultaneous with color_valid. Required: strand_out=0 and request_valid=0 next cycle, capture discarded, 50 low cycles, IDLE, no frame_done. A later frame_start runs normally from index 0.
- Reset: rst_in during SHIFT. Required: all outputs 0 next cycle. frame_start during busy ignored (no second frame).

Source files
------------

// File: rtl/multi_strand_led_driver.sv
// Lockstep WS2812-style driver for several strands sharing one bit-timing engine.
// Colours arrive through an indexed request/valid handshake with a one-LED prefetch buffer.
module multi_strand_led_driver #(
    parameter int NUM_STRANDS  = 4,
    parameter int NUM_LEDS     = 60,
    parameter int COLOR_WIDTH  = 8,
    parameter int T_BIT        = 125,
    parameter int T0H          = 40,
    parameter int T1H          = 80,
    parameter int RESET_CYCLES = 30000,
    localparam int IDX_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               force_reset,
    input  logic                               frame_start,
    input  logic                               mode_continuous,
    input  logic [2:0]                         brightness_shift_in,
    input  logic [NUM_STRANDS*COLOR_WIDTH-1:0] green_in,
    input  logic [NUM_STRANDS*COLOR_WIDTH-1:0] red_in,
    input  logic [NUM_STRANDS*COLOR_WIDTH-1:0] blue_in,
    input  logic                               color_valid,
    output logic [IDX_W-1:0]                   next_led_request,
    output logic                               request_valid,
    output logic [NUM_STRANDS-1:0]             strand_out,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               underrun
);
    localparam int WORD_W = 3 * COLOR_WIDTH;
    localparam int BIT_W  = $clog2(WORD_W);
    localparam int CNT_W  = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam int LAT_W  = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] T0H_C = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C = CNT_W'(T1H);

    typedef enum logic [1:0] {IDLE, FETCH0, SHIFT, LATCH} state_t;

    state_t                               state_reg, state_next;
    logic [CNT_W-1:0]                     bit_cnt_reg, bit_cnt_next;
    logic [BIT_W-1:0]                     bit_idx_reg, bit_idx_next;
    logic [IDX_W-1:0]                     led_idx_reg, led_idx_next;
    logic                                 req_valid_reg, req_valid_next;
    logic [IDX_W-1:0]                     req_idx_reg, req_idx_next;
    logic                                 pf_full_reg, pf_full_next;
    logic [NUM_STRANDS-1:0][WORD_W-1:0]   pf_reg, pf_next;
    logic [NUM_STRANDS-1:0][WORD_W-1:0]   shift_reg, shift_next;
    logic [NUM_STRANDS-1:0][WORD_W-1:0]   shift_adv, fmt_word;
    logic [LAT_W-1:0]                     latch_cnt_reg, latch_cnt_next;
    logic                                 complete_reg, complete_next;
    logic                                 forced_reg, forced_next;
    logic                                 underrun_reg, underrun_next;

    logic capture, bit_end, word_end, last_led, led_first, latch_end;

    assign capture   = req_valid_reg && color_valid;
    assign bit_end   = (bit_cnt_reg == CNT_W'(T_BIT - 1));
    assign word_end  = bit_end && (bit_idx_reg == BIT_W'(WORD_W - 1));
    assign last_led  = (led_idx_reg == IDX_W'(NUM_LEDS - 1));
    assign led_first = (bit_cnt_reg == '0) && (bit_idx_reg == '0);
    assign latch_end = (latch_cnt_reg == LAT_W'(RESET_CYCLES - 1));

    generate
        for (genvar gi = 0; gi < NUM_STRANDS; gi++) begin : g_strand
            assign fmt_word[gi] = {
                COLOR_WIDTH'(green_in[gi*COLOR_WIDTH +: COLOR_WIDTH] >> brightness_shift_in),
                COLOR_WIDTH'(red_in[gi*COLOR_WIDTH +: COLOR_WIDTH] >> brightness_shift_in),
                COLOR_WIDTH'(blue_in[gi*COLOR_WIDTH +: COLOR_WIDTH] >> brightness_shift_in)};
            assign shift_adv[gi]  = {shift_reg[gi][WORD_W-2:0], 1'b0};
            assign strand_out[gi] = (state_reg == SHIFT) &&
                                    (bit_cnt_reg < (shift_reg[gi][WORD_W-1] ? T1H_C : T0H_C));
        end
    endgenerate

    assign request_valid    = req_valid_reg;
    assign next_led_request = req_idx_reg;
    assign busy             = (state_reg != IDLE);
    assign underrun         = underrun_reg;
    assign frame_done       = (state_reg == LATCH) && complete_reg && latch_end;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            led_idx_reg   <= '0;
            req_valid_reg <= 1'b0;
            req_idx_reg   <= '0;
            pf_full_reg   <= 1'b0;
            pf_reg        <= '0;
            shift_reg     <= '0;
            latch_cnt_reg <= '0;
            complete_reg  <= 1'b0;
            forced_reg    <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            led_idx_reg   <= led_idx_next;
            req_valid_reg <= req_valid_next;
            req_idx_reg   <= req_idx_next;
            pf_full_reg   <= pf_full_next;
            pf_reg        <= pf_next;
            shift_reg     <= shift_next;
            latch_cnt_reg <= latch_cnt_next;
            complete_reg  <= complete_next;
            forced_reg    <= forced_next;
            underrun_reg  <= underrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        led_idx_next   = led_idx_reg;
        req_valid_next = req_valid_reg;
        req_idx_next   = req_idx_reg;
        pf_full_next   = pf_full_reg;
        pf_next        = pf_reg;
        shift_next     = shift_reg;
        latch_cnt_next = latch_cnt_reg;
        complete_next  = complete_reg;
        forced_next    = forced_reg;
        underrun_next  = 1'b0;

        if (capture) begin
            req_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (frame_start || mode_continuous) begin
                    state_next     = FETCH0;
                    req_valid_next = 1'b1;
                    req_idx_next   = '0;
                end
            end
            FETCH0: begin
                if (capture) begin
                    shift_next   = fmt_word;
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    led_idx_next = '0;
                end
            end
            SHIFT: begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (capture) begin
                    pf_next      = fmt_word;
                    pf_full_next = 1'b1;
                end
                // Request goes out one cycle after the previous capture so request_valid visibly drops.
                if (led_first && !last_led && !req_valid_reg && !pf_full_reg) begin
                    req_valid_next = 1'b1;
                    req_idx_next   = led_idx_reg + 1'b1;
                end
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (!word_end) begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        shift_next   = shift_adv;
                    end else if (last_led) begin
                        state_next     = LATCH;
                        latch_cnt_next = '0;
                        complete_next  = 1'b1;
                    end else if (pf_full_reg || capture) begin
                        // A capture on the final cycle is forwarded straight into the shifter.
                        shift_next   = pf_full_reg ? pf_reg : fmt_word;
                        pf_full_next = 1'b0;
                        led_idx_next = led_idx_reg + 1'b1;
                        bit_idx_next = '0;
                    end else begin
                        underrun_next  = 1'b1;
                        req_valid_next = 1'b0;
                        state_next     = LATCH;
                        latch_cnt_next = '0;
                        complete_next  = 1'b0;
                    end
                end
            end
            LATCH: begin
                if (latch_end) begin
                    complete_next = 1'b0;
                    forced_next   = 1'b0;
                    if (!forced_reg && mode_continuous) begin
                        state_next     = FETCH0;
                        req_valid_next = 1'b1;
                        req_idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    latch_cnt_next = latch_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (force_reset) begin
            state_next     = LATCH;
            latch_cnt_next = '0;
            req_valid_next = 1'b0;
            pf_full_next   = 1'b0;
            complete_next  = 1'b0;
            forced_next    = 1'b1;
            underrun_next  = 1'b0;
        end
    end
endmodule
